seg7_pair_decoder: RTL

- Decodes a pair of 7-segment displays back into digit values.
- Inputs are two active-low 7-segment buses (tens/high digit, units/low digit) in standard DE10 encoding.
- Synchronises and debounces the buses and commits only stable patterns. Outputs are decoded nibbles, blank/error flags, an update pulse and a change counter.
- Used as an on-board monitor/checker for display drivers and as a loopback decoder in lab benches.

---
 rtl/seg7_pair_decoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seg7_pair_decoder.sv
// Decodes a pair of active-low 7-segment buses into committed digit values once the pattern is stable.
// Build option: define HEX_LETTERS_EN to accept A,b,C,d,E,F as legal digits 10..15.
module seg7_pair_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_hi,
  input  logic [6:0]       seg_lo,
  output logic [7:0]       value,
  output logic             valid,
  output logic             blank_hi,
  output logic             blank_lo,
  output logic             err_hi,
  output logic             err_lo,
  output logic             update,
  output logic [CNT_W-1:0] change_count
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {WAIT, COUNT, SETTLED} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [13:0]   sync_p0, sync_p1, prev_p2, last;
  logic          changed, commit;
  logic [5:0]    dec_hi, dec_lo;

  // Result packing: {err, blank, nibble}
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = {2'b00, 4'h0};
      7'b1111001: decode = {2'b00, 4'h1};
      7'b0100100: decode = {2'b00, 4'h2};
      7'b0110000: decode = {2'b00, 4'h3};
      7'b0011001: decode = {2'b00, 4'h4};
      7'b0010010: decode = {2'b00, 4'h5};
      7'b0000010: decode = {2'b00, 4'h6};
      7'b1111000: decode = {2'b00, 4'h7};
      7'b0000000: decode = {2'b00, 4'h8};
      7'b0010000: decode = {2'b00, 4'h9};
`ifdef HEX_LETTERS_EN
      7'b0001000: decode = {2'b00, 4'hA};
      7'b0000011: decode = {2'b00, 4'hB};
      7'b1000110: decode = {2'b00, 4'hC};
      7'b0100001: decode = {2'b00, 4'hD};
      7'b0000110: decode = {2'b00, 4'hE};
      7'b0001110: decode = {2'b00, 4'hF};
`endif
      7'b1111111: decode = {2'b01, 4'h0};
      default:    decode = {2'b10, 4'h0};
    endcase
  endfunction

  // Stage p0/p1: two-flop synchroniser; p2: previous synchronised pair for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 14'h3FFF;
      sync_p1 <= 14'h3FFF;
      prev_p2 <= 14'h3FFF;
    end else begin
      sync_p0 <= {seg_hi, seg_lo};
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign changed = (sync_p1 != prev_p2);
  assign dec_hi  = decode(sync_p1[13:7]);
  assign dec_lo  = decode(sync_p1[6:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      WAIT: begin
        cnt_nx = '0;
        if (!changed) state_nx = COUNT;
      end
      COUNT: begin
        if (changed) begin
          state_nx = WAIT;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = SETTLED;
          cnt_nx   = '0;
          commit   = (sync_p1 != last);
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      SETTLED: begin
        if (changed) state_nx = WAIT;
      end
      default: state_nx = WAIT;
    endcase
  end

  // Commit stage: outputs only move when a new stable pair differs from the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last         <= 14'h3FFF;
      value        <= '0;
      valid        <= 1'b0;
      blank_hi     <= 1'b0;
      blank_lo     <= 1'b0;
      err_hi       <= 1'b0;
      err_lo       <= 1'b0;
      update       <= 1'b0;
      change_count <= '0;
    end else begin
      update <= commit;
      if (commit) begin
        last         <= sync_p1;
        value        <= {dec_hi[3:0], dec_lo[3:0]};
        blank_hi     <= dec_hi[4];
        blank_lo     <= dec_lo[4];
        err_hi       <= dec_hi[5];
        err_lo       <= dec_lo[5];
        valid        <= ~(dec_hi[5] | dec_hi[4] | dec_lo[5] | dec_lo[4]);
        change_count <= change_count + 1'b1;
      end
    end
  end

endmodule
